// File: rtl/arm_mem_responder_pkg.sv
// Shared definitions for the ArmCpu memory responder.
//   mem_state_e : responder mode (LOAD holds the core in reset and accepts
//                 the program image, RUN serves fetches and data accesses)
//   NOP_INSTR   : instruction returned for an unusable fetch address
//   FAULT_*     : bit positions inside the sticky fault vector
package arm_mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'hE1A00000;  // MOV r0, r0

  localparam int FAULT_FETCH = 0;
  localparam int FAULT_DATA  = 1;
  localparam int FAULT_OVF   = 2;

endpackage

// File: rtl/arm_mem_responder_if.sv
// Bus bundle between ArmCpu (plus program loader) and arm_mem_responder.
//   loader : load_start, load_valid, load_data, load_last -> load_ready
//   core   : pc -> instr, alu_result/write_data/mem_write -> read_data
//   status : cpu_reset, loaded_words, fault, dbg_state (FSM state)
//
// Loader handshake: a byte transfers on a rising clk edge where
// load_valid && load_ready. load_data and load_last are only meaningful
// while load_valid is high; load_ready does not depend on load_valid.
interface arm_mem_responder_if
  import arm_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64
);
  logic                          load_start;
  logic                          load_valid;
  logic [7:0]                    load_data;
  logic                          load_last;
  logic                          load_ready;
  logic                          cpu_reset;
  logic [31:0]                   pc;
  logic [31:0]                   instr;
  logic [31:0]                   alu_result;
  logic [31:0]                   write_data;
  logic                          mem_write;
  logic [31:0]                   read_data;
  logic [$clog2(IMEM_WORDS):0]   loaded_words;
  logic [2:0]                    fault;
  mem_state_e                    dbg_state;

  modport slave (
    input  load_start, load_valid, load_data, load_last,
    input  pc, alu_result, write_data, mem_write,
    output load_ready, cpu_reset, instr, read_data,
    output loaded_words, fault, dbg_state
  );

  modport master (
    output load_start, load_valid, load_data, load_last,
    output pc, alu_result, write_data, mem_write,
    input  load_ready, cpu_reset, instr, read_data,
    input  loaded_words, fault, dbg_state
  );
endinterface

// File: rtl/arm_mem_responder_byte_word_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
//   clk, reset  : clock, asynchronous active-low reset
//   clear       : synchronous restart of the lane index (drops partial word)
//   byte_xfer   : a byte transfers this cycle
//   byte_data   : the byte, placed in lane byte_idx (lane 0 = bits 7:0)
//   byte_last   : final byte of the image; closes the word early
//   word_valid  : combinational, the word completes on this edge
//   word        : completed word, lanes above the last byte read as zero
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_xfer,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]      byte_idx;
  logic [2:0][7:0] lane_q;  // lane 3 is never stored: it always completes a word

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= 2'd0;
      lane_q   <= '0;
    end else if (clear) begin
      byte_idx <= 2'd0;
    end else if (byte_xfer) begin
      for (int i = 0; i < 3; i++) begin
        if (byte_idx == 2'(i)) lane_q[i] <= byte_data;
      end
      byte_idx <= byte_last ? 2'd0 : byte_idx + 2'd1;
    end
  end

  // Lanes at or above byte_idx hold bytes of an older word, so only lanes
  // below the current index are taken from storage; the rest are zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < byte_idx) word[8*i +: 8] = lane_q[i];
    end
    word[{byte_idx, 3'b000} +: 8] = byte_data;
    word_valid = byte_xfer && ((byte_idx == 2'd3) || byte_last);
  end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for ArmCpu: instruction and data memories with
// combinational reads, plus a byte-stream loader that fills instruction
// memory while the core is held in reset.
//   clk    : system clock, all state updates on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : arm_mem_responder_if.slave (loader, fetch/data port, status)
module arm_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_mem_responder_if.slave   bus
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  mem_state_e  state_q, state_d;
  logic [IAW:0] wr_ptr_q;
  logic [2:0]   fault_q;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic        byte_xfer;
  logic        word_valid;
  logic [31:0] word;
  logic        restart;
  logic        store_en;
  logic        fetch_ok;
  logic        data_ok;
  logic        imem_full;

  // Aligned and within the array: no address bits above the word index.
  assign fetch_ok = (bus.pc[1:0] == 2'b00) && (bus.pc[31:IAW+2] == '0);
  assign data_ok  = (bus.alu_result[1:0] == 2'b00) && (bus.alu_result[31:DAW+2] == '0);

  // Depth is a power of two, so the pointer MSB marks "all words written".
  assign imem_full = wr_ptr_q[IAW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    byte_xfer      = 1'b0;
    restart        = 1'b0;
    store_en       = 1'b0;
    bus.load_ready = 1'b0;
    bus.cpu_reset  = 1'b0;
    case (state_q)
      LOAD: begin
        bus.load_ready = 1'b1;
        bus.cpu_reset  = 1'b1;
        // Gated by reset so a byte presented during reset never reaches imem.
        byte_xfer = bus.load_valid && reset;
        if (byte_xfer && bus.load_last) state_d = RUN;
      end
      RUN: begin
        if (bus.load_start) begin
          restart = 1'b1;
          state_d = LOAD;
        end else begin
          store_en = bus.mem_write && data_ok;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_xfer  (byte_xfer),
    .byte_data  (bus.load_data),
    .byte_last  (bus.load_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      fault_q  <= '0;
    end else if (restart) begin
      wr_ptr_q <= '0;
      fault_q  <= '0;
    end else begin
      if (state_q == RUN) begin
        if (!fetch_ok)                  fault_q[FAULT_FETCH] <= 1'b1;
        if (bus.mem_write && !data_ok)  fault_q[FAULT_DATA]  <= 1'b1;
      end
      if (word_valid) begin
        if (imem_full) fault_q[FAULT_OVF] <= 1'b1;
        else           wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Memory arrays carry no reset; contents survive reset and reloads.
  always_ff @(posedge clk) begin
    if (word_valid && !imem_full) imem[wr_ptr_q[IAW-1:0]] <= word;
    if (store_en)                 dmem[bus.alu_result[DAW+1:2]] <= bus.write_data;
  end

  // Reads are combinational and see the pre-edge contents (old data on a
  // same-cycle read/write of one word).
  assign bus.instr        = fetch_ok ? imem[bus.pc[IAW+1:2]] : NOP_INSTR;
  assign bus.read_data    = data_ok ? dmem[bus.alu_result[DAW+1:2]] : 32'h0;
  assign bus.loaded_words = wr_ptr_q;
  assign bus.fault        = fault_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_arm_mem_responder.sv
module tb_arm_mem_responder;
  import arm_mem_pkg::*;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_mem_responder_if #(.IMEM_WORDS(IMEM_WORDS)) bus ();

  arm_mem_responder #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  localparam int K_INSTR  = 0;
  localparam int K_RDATA  = 1;
  localparam int K_LOADED = 2;
  localparam int K_FAULT  = 3;
  localparam int K_CPURST = 4;
  localparam int K_LREADY = 5;
  localparam int K_STATE  = 6;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_out(input int k, input string n, input logic [31:0] v);
    kind_q.push_back(k);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  function automatic logic [31:0] dut_value(input int k);
    case (k)
      K_INSTR:  return bus.instr;
      K_RDATA:  return bus.read_data;
      K_LOADED: return 32'(bus.loaded_words);
      K_FAULT:  return 32'(bus.fault);
      K_CPURST: return 32'(bus.cpu_reset);
      K_LREADY: return 32'(bus.load_ready);
      default:  return 32'(bus.dbg_state);
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, half a cycle after
  // the driver has settled inputs and the registers have updated.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      int          k;
      string       n;
      logic [31:0] e;
      logic [31:0] a;
      k = kind_q.pop_front();
      n = name_q.pop_front();
      e = exp_q.pop_front();
      a = dut_value(k);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] imem_m [IMEM_WORDS];
  bit          imem_v [IMEM_WORDS];
  logic [31:0] dmem_m [DMEM_WORDS];
  bit          dmem_v [DMEM_WORDS];
  logic [2:0]  fault_m;
  int          loaded_m;
  logic [7:0]  img_q[$];

  function automatic bit fetch_good(input logic [31:0] p);
    return (p % 4 == 0) && (p / 4 < IMEM_WORDS);
  endfunction

  function automatic bit data_good(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DMEM_WORDS);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.pc         = 32'h0;
    bus.alu_result = 32'h0;
    bus.write_data = 32'h0;
    bus.mem_write  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      bus.load_valid = 1'b0;
      bus.load_data  = 8'($urandom_range(0, 255));
      bus.load_last  = 1'($urandom_range(0, 1));
      tick();
    end
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic expect_status(input string tag);
    expect_out(K_LOADED, {tag, "_loaded"}, 32'(loaded_m));
    expect_out(K_FAULT,  {tag, "_fault"},  32'(fault_m));
  endtask

  // Streams img_q (last flag on the final byte) and predicts the words.
  task automatic load_image(input string tag);
    int          n;
    int          nwords;
    logic [31:0] w;
    n = img_q.size();
    for (int i = 0; i < n; i++) send_byte(img_q[i], i == n - 1);
    nwords   = (n + 3) / 4;
    loaded_m = 0;
    for (int j = 0; j < nwords; j++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (4 * j + b < n) w = w | (32'(img_q[4 * j + b]) << (8 * b));
      end
      if (j < IMEM_WORDS) begin
        imem_m[j] = w;
        imem_v[j] = 1'b1;
        loaded_m  = j + 1;
      end else begin
        fault_m[FAULT_OVF] = 1'b1;
      end
    end
    expect_out(K_STATE,  {tag, "_state"},      32'(RUN));
    expect_out(K_CPURST, {tag, "_cpu_reset"},  32'h0);
    expect_out(K_LREADY, {tag, "_load_ready"}, 32'h0);
    expect_status(tag);
  endtask

  task automatic pulse_load_start(input string tag, input logic mw,
                                  input logic [31:0] a, input logic [31:0] wd);
    bus.load_start = 1'b1;
    bus.mem_write  = mw;
    bus.alu_result = a;
    bus.write_data = wd;
    tick();
    drive_idle();
    fault_m  = 3'b000;
    loaded_m = 0;
    expect_out(K_STATE,  {tag, "_state"},      32'(LOAD));
    expect_out(K_CPURST, {tag, "_cpu_reset"},  32'h1);
    expect_out(K_LREADY, {tag, "_load_ready"}, 32'h1);
    expect_status(tag);
  endtask

  // One core cycle in RUN: checks the combinational reads for the driven
  // addresses, then the memory/fault effect after the edge.
  task automatic run_cycle(input string tag, input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] wd, input logic mw);
    bus.pc         = p;
    bus.alu_result = a;
    bus.write_data = wd;
    bus.mem_write  = mw;
    if (!fetch_good(p))          expect_out(K_INSTR, {tag, "_instr"}, NOP_INSTR);
    else if (imem_v[p / 4])      expect_out(K_INSTR, {tag, "_instr"}, imem_m[p / 4]);
    if (!data_good(a))           expect_out(K_RDATA, {tag, "_rdata"}, 32'h0);
    else if (dmem_v[a / 4])      expect_out(K_RDATA, {tag, "_rdata"}, dmem_m[a / 4]);
    tick();
    drive_idle();
    if (!fetch_good(p)) fault_m[FAULT_FETCH] = 1'b1;
    if (mw) begin
      if (data_good(a)) begin
        dmem_m[a / 4] = wd;
        dmem_v[a / 4] = 1'b1;
      end else begin
        fault_m[FAULT_DATA] = 1'b1;
      end
    end
    expect_out(K_FAULT, {tag, "_fault"}, 32'(fault_m));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem_v[i] = 1'b0;
    for (int i = 0; i < DMEM_WORDS; i++) dmem_v[i] = 1'b0;
    fault_m  = 3'b000;
    loaded_m = 0;
    drive_idle();
    reset = 1'b0;

    // Reset state
    tick();
    expect_out(K_STATE,  "rst_state",      32'(LOAD));
    expect_out(K_CPURST, "rst_cpu_reset",  32'h1);
    expect_out(K_LREADY, "rst_load_ready", 32'h1);
    expect_status("rst");
    tick();
    reset = 1'b1;
    tick();

    // Two-word program image
    img_q = '{8'h00, 8'h00, 8'hA0, 8'hE1, 8'h01, 8'h00, 8'h80, 8'hE2};
    load_image("img2");
    checks++;
    if (bus.loaded_words !== 7'd2) begin
      errors++;
      $display("FAIL img2_direct_loaded: got %0d expected 2", bus.loaded_words);
    end
    checks++;
    if (bus.cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL img2_direct_cpu_reset: got %b expected 0", bus.cpu_reset);
    end
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL img2_direct_load_ready: got %b expected 0", bus.load_ready);
    end
    run_cycle("img2_w1", 32'd4, 32'd0, 32'd0, 1'b0);
    run_cycle("img2_w0", 32'd0, 32'd0, 32'd0, 1'b0);

    // Short image: zero-padded word; imem[1] from before is kept
    pulse_load_start("ls1", 1'b0, 32'd0, 32'd0);
    img_q = '{8'h11, 8'h22};
    load_image("img_short");
    run_cycle("short_w0", 32'd0, 32'd0, 32'd0, 1'b0);
    run_cycle("short_w1", 32'd4, 32'd0, 32'd0, 1'b0);

    // Store then load, plus same-cycle read of the stored word
    run_cycle("st8",  32'd0, 32'd8, 32'hDEADBEEF, 1'b0);
    run_cycle("st8",  32'd0, 32'd8, 32'hDEADBEEF, 1'b1);
    run_cycle("ld8",  32'd0, 32'd8, 32'h0, 1'b0);
    run_cycle("rmw8", 32'd4, 32'd8, 32'h0BADF00D, 1'b1);
    run_cycle("ld8b", 32'd0, 32'd8, 32'h0, 1'b0);

    // Randomised data traffic
    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = $urandom_range(0, DMEM_WORDS - 1);
      if (!dmem_v[idx] || $urandom_range(0, 1) == 1)
        run_cycle("rnd_st", 32'd0, 32'(4 * idx), $urandom, 1'b1);
      else
        run_cycle("rnd_ld", 32'd4, 32'(4 * idx), 32'h0, 1'b0);
    end

    // Bad accesses: words 0 and 1 are what a wrong address decode would hit
    run_cycle("pre0", 32'd0, 32'd0, 32'h01010101, 1'b1);
    run_cycle("pre1", 32'd0, 32'd4, 32'h02020202, 1'b1);
    run_cycle("badld", 32'd0, 32'd6, 32'h0, 1'b0);
    run_cycle("badst6", 32'd0, 32'd6, 32'hFFFF0000, 1'b1);
    run_cycle("badst_hi", 32'd0, 32'(4 * DMEM_WORDS), 32'h12345678, 1'b1);
    run_cycle("chk0", 32'd0, 32'd0, 32'h0, 1'b0);
    run_cycle("chk1", 32'd0, 32'd4, 32'h0, 1'b0);
    run_cycle("badpc2", 32'd2, 32'd0, 32'h0, 1'b0);
    run_cycle("badpc_hi", 32'(4 * IMEM_WORDS), 32'd0, 32'h0, 1'b0);

    // Overflowing image
    pulse_load_start("ls_ovf", 1'b0, 32'd0, 32'd0);
    img_q.delete();
    for (int i = 0; i < 4 * IMEM_WORDS + 4; i++) img_q.push_back(8'($urandom_range(0, 255)));
    load_image("img_ovf");
    run_cycle("ovf_w0",  32'd0, 32'd0, 32'h0, 1'b0);
    run_cycle("ovf_wlast", 32'(4 * (IMEM_WORDS - 1)), 32'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_cycle("ovf_rnd", 32'(4 * $urandom_range(0, IMEM_WORDS - 1)), 32'd0, 32'h0, 1'b0);

    // Reset in the middle of a word
    pulse_load_start("ls_rst", 1'b0, 32'd0, 32'd0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    drive_idle();
    reset    = 1'b0;
    fault_m  = 3'b000;
    loaded_m = 0;
    expect_out(K_STATE,  "midrst_state",     32'(LOAD));
    expect_out(K_CPURST, "midrst_cpu_reset", 32'h1);
    expect_status("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load_image("img_after_rst");
    run_cycle("after_rst_w0", 32'd0, 32'd0, 32'h0, 1'b0);
    run_cycle("after_rst_w1", 32'd4, 32'd0, 32'h0, 1'b0);

    // load_start wins over a same-cycle store
    pulse_load_start("ls_st", 1'b1, 32'd8, 32'hCAFEF00D);
    img_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    load_image("img_final");
    run_cycle("suppressed_st", 32'd4, 32'd8, 32'h0, 1'b0);
    run_cycle("final_w0",      32'd0, 32'd0, 32'h0, 1'b0);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mem_responder.md
Name: arm_mem_responder

Overview:
- Memory-side responder for the ArmCpu core. It answers instruction fetches on pc/instr and data accesses on alu_result/write_data/mem_write/read_data.
- It also owns a byte-stream program loader that fills instruction memory while holding the core in reset.
- It sits beside ArmCpu at top level and replaces the hand-driven instr/read_data stimulus used in core benches.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse in RUN that re-enters LOAD.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte, little-endian within each word.
- load_last  in  1  qualifies the final byte of the image.
- load_ready  out  1  loader may transfer; high only in LOAD.
- cpu_reset  out  1  active-high reset to ArmCpu; high in LOAD.
- pc  in  32  fetch address from the core.
- instr  out  32  fetched instruction (combinational).
- alu_result  in  32  data byte address.
- write_data  in  32  store data.
- mem_write  in  1  store strobe.
- read_data  out  32  load data (combinational).
- loaded_words  out  $clog2(IMEM_WORDS)+1  words written by the last load.
- fault  out  3  sticky flags: [0] misaligned/out-of-range fetch, [1] bad data access, [2] load overflow.

Behaviour:
- States: LOAD, RUN.
- Reset values (asynchronous, while reset=0): state=LOAD, byte_idx=0, wr_ptr=0, loaded_words=0, fault=0, cpu_reset=1, load_ready=1. Memory contents are not reset.
- LOAD state:
  - A byte transfers when load_valid && load_ready.
  - Each transferred byte fills lane byte_idx (byte 0 = bits 7:0), then byte_idx increments mod 4.
  - Completing lane 3 writes the word to imem[wr_ptr] on that edge and increments wr_ptr.
  - Bytes with load_valid=0 are ignored.
  - If a transfer has load_last=1, the current word is written with unfilled lanes zero-padded (zero bytes already in progress → no write), and state→RUN on the same edge.
  - If a completed word arrives with wr_ptr==IMEM_WORDS, the word is dropped, fault[2] is set, and wr_ptr saturates.
  - loaded_words = wr_ptr, updated each write.
- RUN state:
  - cpu_reset=0 from the first cycle in RUN; the core's first fetch is pc=0.
  - instr = imem[pc>>2] when pc[1:0]==0 and pc>>2 < IMEM_WORDS.
  - Otherwise instr=32'hE1A00000 (NOP) and fault[0] is set at the next edge.
  - read_data = dmem[alu_result>>2] for an aligned, in-range address, else 0.
  - A store writes dmem on the rising edge when mem_write=1, the address is aligned and in range, and state==RUN.
  - A bad store is ignored and sets fault[1]; a bad load with mem_write=0 does not set fault.
  - load_start=1: state→LOAD, wr_ptr=0, byte_idx=0, loaded_words=0, fault cleared.
  - load_start has priority over a same-cycle mem_write: the store is suppressed.
  - cpu_reset rises on the edge that enters LOAD.
- mem_write and pc are ignored in LOAD; instr and read_data still reflect the arrays combinationally.
- Reset asserted mid-load: partial word discarded; already-written imem words remain.
- A read and write of the same dmem word in one cycle return the old data (write-first is not used).

Decomposition:
- Package arm_mem_pkg holds:
  - state enum {LOAD, RUN};
  - NOP_INSTR = 32'hE1A00000;
  - fault bit index constants FAULT_FETCH=0, FAULT_DATA=1, FAULT_OVF=2.
- Sub-module byte_word_packer (byte lanes, byte_idx, zero-pad on last, emits word_valid/word).
- The top module holds the FSM, arrays, and access checks.

Test Plan:
- Stream bytes 00,00,A0,E1,01,00,80,E2 (last on 8th) → imem[0]=E1A00000, imem[1]=E2800001, loaded_words=2, cpu_reset falls on the edge after byte 8, load_ready=0; pc=4 → instr=E2800001.
- Stream bytes 11,22 with last on 22 → imem[0]=00002211, loaded_words=1, RUN.
- RUN: mem_write=1, alu_result=8, write_data=DEADBEEF; next cycle mem_write=0, alu_result=8 → read_data=DEADBEEF, fault=0.
- RUN: store to alu_result=6 and to 4*DMEM_WORDS → no dmem change, fault[1]=1; pc=2 → instr=E1A00000 and fault[0]=1 after the edge.
- Load 4*IMEM_WORDS+4 bytes → loaded_words=IMEM_WORDS, fault[2]=1, imem[0] holds the first word.
- Assert reset after 2 bytes of a word, release, then stream 4 bytes AA,BB,CC,DD (last) → imem[0]=DDCCBBAA, no stale lanes; load_start with same-cycle mem_write → store suppressed, cpu_reset=1 next cycle.
